uart_rx: RTL and testbench

//  Serial 8N1 UART receiver feeding the system's byte-stream consumers from the raw uart_rx pin.

---
 rtl/uart_rx.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-FF input synchroniser, a bit-centre timer
// and a small byte FIFO with a valid/ready pop interface.
// Optional 8E1 framing is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int unsigned CLK_HZ = 6000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned TW  = $clog2(DIV);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [TW-1:0] T_HALF = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    logic          rx_s1_q, rx_s2_q;
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          rxs, tick, push, pop, full, empty, push_ok;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d;
    logic          parity_err_q, parity_err_d;
`endif

    assign rxs   = rx_s2_q;
    assign tick  = (timer_q == '0);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Receive FSM: next state, bit timer, shift register and error pulses.
    always_comb begin
        state_d     = state_q;
        timer_d     = tick ? timer_q : timer_q - 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    timer_d = T_HALF;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        timer_d   = T_FULL;
                        bit_idx_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {rxs, shift_q[7:1]};
                    timer_d = T_FULL;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    par_bad_d    = (rxs != ^shift_q);
                    parity_err_d = (rxs != ^shift_q);
                    timer_d      = T_FULL;
                    state_d      = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (rxs) begin
`ifdef UART_RX_PARITY_EN
                        push = !par_bad_q;
`else
                        push = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO: a pop in the same cycle frees the slot a push into a full FIFO needs.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pop       = !empty && rx_ready;
        push_ok   = push && (!full || pop);
        overrun_d = push && full && !pop;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = shift_q;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // State registers with synchronous reset; synchroniser resets to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_s1_q     <= rx;
            rx_s2_q     <= rx_s1_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = mem_q[rd_ptr_q[AW-1:0]];
    assign rx_valid  = !empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames plus hand-written corner sequences for uart_rx;
// received bytes are checked against a scoreboard queue filled when frames are sent.
module tb_uart_rx;

    localparam int unsigned BITC = 52;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ON = 1'b1;
    localparam int   LAT    = 549;
`else
    localparam logic PAR_ON = 1'b0;
    localparam int   LAT    = 497;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, parity_err;

    int checks = 0;
    int failures = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int perr_cnt = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_push;
        logic       exp_ferr;
    } vec_t;
    vec_t vecs [7];

    uart_rx #(.CLK_HZ(6000000), .BAUD(115200), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, counts error-pulse cycles.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (parity_err) perr_cnt++;
            if (rx_valid && rx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pop_unexpected actual=%0h required=none", rx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        failures++;
                        $display("FAIL pop_data actual=%0h required=%0h", rx_data, e);
                    end
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int unsigned extra_low,
                              input logic with_par, input logic par_bit);
        rx = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BITC) @(negedge clk);
        end
        if (with_par) begin
            rx = par_bit;
            repeat (BITC) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BITC * (1 + extra_low)) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, 1'b1, 0, PAR_ON, ^d);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int lat, f0, o0;
        logic [7:0] d99;
        vecs[0] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h5A, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h81, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h7E, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'hC3, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_parity_err", int'(parity_err), 0);
        rst = 1'b0;
        repeat (BITC) @(negedge clk);

        // 1. exact latency, single-cycle rx_valid with ready held high
        rx_ready = 1'b1;
        exp_q.push_back(8'h55);
        lat = 0;
        fork
            send_byte(8'h55);
            begin
                while (!rx_valid && lat < 1000) begin
                    @(negedge clk);
                    lat++;
                end
                @(negedge clk);
                check("valid_one_cycle", int'(rx_valid), 0);
            end
        join
        check("latency", lat, LAT);
        repeat (2 * BITC) @(negedge clk);
        check("t1_drained", exp_q.size(), 0);

        // table-driven frames: good and bad stop bits
        for (int i = 0; i < 7; i++) begin
            f0 = ferr_cnt;
            if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop, 0, PAR_ON, ^vecs[i].data);
            repeat (2 * BITC) @(negedge clk);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, int'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_queue", i), exp_q.size(), 0);
        end

        // 2. overrun on the fifth byte, then ordered drain
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h80);
        send_byte(8'h01); repeat (BITC) @(negedge clk);
        send_byte(8'hA5); repeat (BITC) @(negedge clk);
        send_byte(8'hFF); repeat (BITC) @(negedge clk);
        send_byte(8'h80); repeat (BITC) @(negedge clk);
        check("ovr_none_yet", ovr_cnt - o0, 0);
        send_byte(8'h3C); repeat (BITC) @(negedge clk);
        check("ovr_pulse", ovr_cnt - o0, 1);
        check("ovr_valid", int'(rx_valid), 1);
        check("ovr_head", int'(rx_data), 8'h01);
        rx_ready = 1'b1;
        drain("ovr_drain");
        repeat (3) @(negedge clk);
        check("ovr_valid_fall", int'(rx_valid), 0);

        // 3. short glitch is ignored
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (12 * BITC) @(negedge clk);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_valid", int'(rx_valid), 0);
        exp_q.push_back(8'h33);
        send_byte(8'h33);
        drain("glitch_next");

        // 4. low stop bit followed by a long break
        f0 = ferr_cnt;
        send_frame(8'h42, 1'b0, 30, PAR_ON, ^8'h42);
        repeat (BITC) @(negedge clk);
        check("break_ferr", ferr_cnt - f0, 1);
        check("break_valid", int'(rx_valid), 0);
        exp_q.push_back(8'h43);
        send_byte(8'h43);
        drain("break_next");
        check("break_ferr_after", ferr_cnt - f0, 1);

        // 5. reset during bit 4 aborts the frame
        d99 = 8'h99;
        rx = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d99[i];
            repeat (BITC) @(negedge clk);
        end
        rx = d99[4];
        repeat (BITC / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rx = 1'b1;
        check("midrst_data", int'(rx_data), 0);
        repeat (12 * BITC) @(negedge clk);
        check("midrst_valid", int'(rx_valid), 0);
        exp_q.push_back(8'h12);
        send_byte(8'h12);
        drain("midrst_next");

`ifdef UART_RX_PARITY_EN
        // 6. even parity: good byte kept, bad parity discarded
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 0, 1'b1, 1'b1);
        drain("par_good");
        f0 = perr_cnt;
        send_frame(8'h07, 1'b1, 0, 1'b1, 1'b0);
        repeat (2 * BITC) @(negedge clk);
        check("par_err_pulse", perr_cnt - f0, 1);
        check("par_no_push", int'(rx_valid), 0);
`else
        check("parity_err_never", perr_cnt, 0);
`endif

        repeat (BITC) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
